// File: rtl/smart_systolic_ctrl_if.sv
// Control/status bundle between the systolic sequencer and whoever drives it.
// The controller is the slave side; the host/testbench is the master side.
interface smart_systolic_ctrl_if #(
   parameter int K_WIDTH = 8,
   parameter int ROW_W   = 2
);
   logic               start;
   logic [K_WIDTH-1:0] k_len;
   logic               smart_en;
   logic               abort;
   logic               feed_ready;
   logic               busy;
   logic               done;
   logic               err;
   logic               array_en;
   logic               feed_valid;
   logic               drain_valid;
   logic [ROW_W-1:0]   drain_row;
   logic               fsm_op2_select;
   logic               fsm_out_select;
   logic               stat_bit;
   logic               capture_smart_left_sel;
   logic               capture_smart_top_sel;
   logic               latch_smart_right_sel;
   logic               latch_smart_bottom_sel;

   modport master (
      output start, k_len, smart_en, abort, feed_ready,
      input  busy, done, err, array_en, feed_valid, drain_valid, drain_row,
             fsm_op2_select, fsm_out_select, stat_bit,
             capture_smart_left_sel, capture_smart_top_sel,
             latch_smart_right_sel, latch_smart_bottom_sel
   );

   modport slave (
      input  start, k_len, smart_en, abort, feed_ready,
      output busy, done, err, array_en, feed_valid, drain_valid, drain_row,
             fsm_op2_select, fsm_out_select, stat_bit,
             capture_smart_left_sel, capture_smart_top_sel,
             latch_smart_right_sel, latch_smart_bottom_sel
   );
endinterface

// File: rtl/smart_systolic_ctrl.sv
// Sequencer for one smart_systolic_cell tile: clear, stream K beats through the
// skew fill, drain CELL_HEIGHT result rows, pulse done.
module smart_systolic_ctrl #(
   parameter int CELL_WIDTH  = 4,
   parameter int CELL_HEIGHT = 4,
   parameter int K_WIDTH     = 8,
   parameter int SMART_SKEW  = 2
) (
   input logic clk,
   input logic rst,
   smart_systolic_ctrl_if.slave bus
);
   localparam int ROW_W     = (CELL_HEIGHT > 1) ? $clog2(CELL_HEIGHT) : 1;
   localparam int CNT_W     = (K_WIDTH + 1 > ROW_W) ? K_WIDTH + 1 : ROW_W;
   localparam int FULL_SKEW = CELL_WIDTH + CELL_HEIGHT - 2;

   localparam logic [CNT_W-1:0] SKEW_SMART = CNT_W'(SMART_SKEW);
   localparam logic [CNT_W-1:0] SKEW_FULL  = CNT_W'(FULL_SKEW);
   localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(CELL_HEIGHT - 1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COMPUTE, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic busy;
      logic done;
      logic array_en;
      logic op2_sel;
      logic out_sel;
      logic stat;
      logic drain_valid;
      logic cap_sel;
      logic lat_sel;
      logic feed_win;
   } ctrl_t;

   state_t             state;
   ctrl_t              ctrl_q;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_inc;
   logic [CNT_W-1:0]   last_cnt;
   logic [K_WIDTH-1:0] k_q;
   logic               smart_q;
   logic               err_q;
   logic [ROW_W-1:0]   row_q;
   logic               stall;

   // Output decode for the state being entered, so every control is a flop.
   function automatic ctrl_t decode(state_t s, logic smart, logic win);
      ctrl_t c;
      c = '0;
      case (s)
         S_CLEAR: begin
            c.busy     = 1'b1;
            c.array_en = 1'b1;
         end
         S_COMPUTE: begin
            c.busy     = 1'b1;
            c.array_en = 1'b1;
            c.op2_sel  = 1'b1;
            c.cap_sel  = smart;
            c.feed_win = win;
         end
         S_DRAIN: begin
            c.busy        = 1'b1;
            c.array_en    = 1'b1;
            c.op2_sel     = 1'b1;
            c.out_sel     = 1'b1;
            c.stat        = 1'b1;
            c.drain_valid = 1'b1;
            c.lat_sel     = smart;
         end
         S_DONE: begin
            c.busy = 1'b1;
            c.done = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   assign cnt_inc  = cnt + CNT_W'(1);
   assign last_cnt = CNT_W'(k_q) + (smart_q ? SKEW_SMART : SKEW_FULL) - CNT_W'(1);
   // feed_win is only set while cnt<k_q in COMPUTE; the skew tail never stalls.
   assign stall    = ctrl_q.feed_win & ~bus.feed_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         ctrl_q  <= '0;
         cnt     <= '0;
         k_q     <= '0;
         smart_q <= 1'b0;
         err_q   <= 1'b0;
         row_q   <= '0;
      end else begin
         err_q <= 1'b0;
         if (bus.abort && state != S_IDLE) begin
            state  <= S_IDLE;
            ctrl_q <= '0;
            cnt    <= '0;
            row_q  <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.start) begin
                     if (bus.k_len != '0) begin
                        k_q     <= bus.k_len;
                        smart_q <= bus.smart_en;
                        state   <= S_CLEAR;
                        ctrl_q  <= decode(S_CLEAR, bus.smart_en, 1'b0);
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               S_CLEAR: begin
                  state  <= S_COMPUTE;
                  cnt    <= '0;
                  ctrl_q <= decode(S_COMPUTE, smart_q, 1'b1);
               end
               S_COMPUTE: begin
                  if (!stall) begin
                     if (cnt == last_cnt) begin
                        state  <= S_DRAIN;
                        cnt    <= '0;
                        row_q  <= '0;
                        ctrl_q <= decode(S_DRAIN, smart_q, 1'b0);
                     end else begin
                        cnt    <= cnt_inc;
                        ctrl_q <= decode(S_COMPUTE, smart_q, cnt_inc < CNT_W'(k_q));
                     end
                  end
               end
               S_DRAIN: begin
                  if (cnt == LAST_ROW) begin
                     state  <= S_DONE;
                     cnt    <= '0;
                     row_q  <= '0;
                     ctrl_q <= decode(S_DONE, smart_q, 1'b0);
                  end else begin
                     cnt   <= cnt_inc;
                     row_q <= ROW_W'(cnt_inc);
                  end
               end
               S_DONE: begin
                  state  <= S_IDLE;
                  ctrl_q <= '0;
               end
               default: begin
                  state  <= S_IDLE;
                  ctrl_q <= '0;
               end
            endcase
         end
      end
   end

   assign bus.busy                   = ctrl_q.busy;
   assign bus.done                   = ctrl_q.done;
   assign bus.err                    = err_q;
   assign bus.array_en               = ctrl_q.array_en & ~stall;
   assign bus.feed_valid             = ctrl_q.feed_win & bus.feed_ready;
   assign bus.drain_valid            = ctrl_q.drain_valid;
   assign bus.drain_row              = row_q;
   assign bus.fsm_op2_select         = ctrl_q.op2_sel;
   assign bus.fsm_out_select         = ctrl_q.out_sel;
   assign bus.stat_bit               = ctrl_q.stat;
   assign bus.capture_smart_left_sel = ctrl_q.cap_sel;
   assign bus.capture_smart_top_sel  = ctrl_q.cap_sel;
   assign bus.latch_smart_right_sel  = ctrl_q.lat_sel;
   assign bus.latch_smart_bottom_sel = ctrl_q.lat_sel;
endmodule

// File: tb/tb_smart_systolic_ctrl.sv
// Directed bench for smart_systolic_ctrl: run lengths, stalls, err, abort, reset.
module tb_smart_systolic_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   smart_systolic_ctrl_if #(.K_WIDTH(8), .ROW_W(2)) bus ();

   smart_systolic_ctrl #(
      .CELL_WIDTH(4), .CELL_HEIGHT(4), .K_WIDTH(8), .SMART_SKEW(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [14:0] allOuts();
      return {bus.busy, bus.done, bus.err, bus.array_en, bus.feed_valid, bus.drain_valid,
              bus.drain_row, bus.fsm_op2_select, bus.fsm_out_select, bus.stat_bit,
              bus.capture_smart_left_sel, bus.capture_smart_top_sel,
              bus.latch_smart_right_sel, bus.latch_smart_bottom_sel};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle start pulse; returns just after the accept edge (cycle 1).
   task automatic applyStimulus(input int k, input bit smart);
      bus.k_len    = k[7:0];
      bus.smart_en = smart;
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
   endtask

   task automatic runCheck(input string tag, input int k, input bit smart, input int stall_len,
                           input bit mid_start, input int exp_done, input int exp_feeds,
                           input int exp_compute);
      int  done_cyc, feeds, comp, drains, busy_cyc, stall_left, sel_err;
      bit  in_comp;
      done_cyc = 0; feeds = 0; comp = 0; drains = 0; busy_cyc = 0; sel_err = 0;
      stall_left = stall_len;
      applyStimulus(k, smart);
      for (int cyc = 1; cyc <= 400 && done_cyc == 0; cyc++) begin
         in_comp = bus.fsm_op2_select && !bus.fsm_out_select;
         bus.start = mid_start && cyc >= 3 && cyc <= 5;
         if (mid_start) bus.k_len = 8'd5;
         bus.feed_ready = 1'b1;
         if (in_comp && feeds == 1 && stall_left > 0) begin
            bus.feed_ready = 1'b0;
            stall_left--;
         end
         #1;
         if (cyc == 1)
            checkOutput({tag, " clear"}, 32'({bus.busy, bus.array_en, bus.fsm_op2_select, bus.feed_valid}), 32'hC);
         if (!bus.feed_ready)
            checkOutput({tag, " stall"}, 32'({bus.array_en, bus.feed_valid}), 32'h0);
         if (bus.feed_valid) feeds++;
         if (in_comp) comp++;
         if (bus.capture_smart_left_sel != (in_comp && smart) ||
             bus.capture_smart_top_sel  != (in_comp && smart)) sel_err++;
         if (bus.latch_smart_right_sel  != (bus.drain_valid && smart) ||
             bus.latch_smart_bottom_sel != (bus.drain_valid && smart)) sel_err++;
         if (bus.drain_valid) begin
            checkOutput({tag, " drain_row"}, 32'(bus.drain_row), 32'(drains));
            checkOutput({tag, " out_stat_en"},
                        32'({bus.fsm_out_select, bus.stat_bit, bus.array_en}), 32'h7);
            drains++;
         end
         if (bus.busy) busy_cyc++;
         if (bus.done) done_cyc = cyc;
         step();
      end
      bus.start = 1'b0;
      bus.feed_ready = 1'b1;
      checkOutput({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
      checkOutput({tag, " feed_beats"}, 32'(feeds), 32'(exp_feeds));
      checkOutput({tag, " compute_cycles"}, 32'(comp), 32'(exp_compute));
      checkOutput({tag, " drain_cycles"}, 32'(drains), 32'd4);
      checkOutput({tag, " busy_cycles"}, 32'(busy_cyc), 32'(exp_done));
      checkOutput({tag, " smart_sels"}, 32'(sel_err), 32'd0);
      checkOutput({tag, " idle_after"}, 32'(allOuts()), 32'd0);
   endtask

   initial begin
      int  seen;
      bit  hit;
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.k_len      = '0;
      bus.smart_en   = 1'b0;
      bus.abort      = 1'b0;
      bus.feed_ready = 1'b1;
      step();
      step();
      checkOutput("reset_outs", 32'(allOuts()), 32'd0);
      rst = 1'b0;
      step();
      checkOutput("post_reset_outs", 32'(allOuts()), 32'd0);

      runCheck("base_k3", 3, 1'b0, 0, 1'b0, 15, 3, 9);
      runCheck("smart_k3", 3, 1'b1, 0, 1'b0, 11, 3, 5);
      runCheck("stall_k3", 3, 1'b0, 2, 1'b0, 17, 3, 11);

      // Rejected start: err for one cycle only, never busy.
      bus.k_len = 8'd0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checkOutput("err_pulse", 32'({bus.err, bus.busy}), 32'h2);
      step();
      checkOutput("err_clear", 32'({bus.err, bus.busy, bus.done}), 32'h0);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.done || bus.busy) seen++;
         step();
      end
      checkOutput("err_no_run", 32'(seen), 32'd0);

      // Abort at drain_row 2.
      applyStimulus(3, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         if (bus.drain_valid && bus.drain_row == 2'd2) hit = 1'b1;
         else step();
      end
      checkOutput("abort_reach_row2", 32'(hit), 32'd1);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      checkOutput("abort_outs", 32'(allOuts()), 32'd0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.done) seen++;
         step();
      end
      checkOutput("abort_no_done", 32'(seen), 32'd0);
      runCheck("restart_k1", 1, 1'b0, 0, 1'b0, 13, 1, 7);

      // Asynchronous reset in the middle of COMPUTE, away from any clock edge.
      applyStimulus(3, 1'b0);
      step();
      step();
      checkOutput("pre_reset_busy", 32'(bus.busy), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_reset_outs", 32'(allOuts()), 32'd0);
      step();
      rst = 1'b0;
      step();
      checkOutput("async_reset_idle", 32'(allOuts()), 32'd0);

      runCheck("busy_start_ignored", 3, 1'b0, 0, 1'b1, 15, 3, 9);
      runCheck("kmax", 255, 1'b0, 0, 1'b0, 267, 255, 261);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
